// File: rtl/apb3_pkg.sv
// Shared definitions for the APB3 master bridge: the transfer FSM state
// encoding and an elaboration-time ceiling-log2 helper.
package apb3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Ceiling log2 for parameter arithmetic (clog2(1) = 0, clog2(2) = 1, ...).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/apb3_addr_decoder.sv
// Maps a command address onto a one-hot slave select plus the binary slave
// index. The slave is chosen by the top log2(NUM_SLAVES) address bits; a
// single-slave system always selects slave 0.
module apb3_addr_decoder
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_SLAVES = 2,
    parameter int IDX_W      = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [IDX_W-1:0]      idx
);

    // The low address bits are the offset inside the slave and play no part
    // in choosing it; they are folded here only so they count as consumed.
    logic unused_addr_bits;

    if (NUM_SLAVES == 1) begin : g_single
        assign idx              = '0;
        assign unused_addr_bits = ^addr;
    end else begin : g_multi
        assign idx              = addr[ADDR_WIDTH-1 -: IDX_W];
        assign unused_addr_bits = ^addr[ADDR_WIDTH-IDX_W-1:0];
    end

    // One-hot expansion of the slave index.
    always_comb begin
        // NOTE: default first, so every path assigns sel and no latch is inferred.
        sel      = '0;
        sel[idx] = 1'b1;
    end

endmodule

// File: rtl/apb3_master_bridge.sv
// Command-to-APB3 master bridge. A command accepted in IDLE is carried
// through one SETUP cycle and one or more ACCESS cycles on the decoded
// slave, then answered with a single-cycle response pulse. An optional
// ACCESS-cycle timeout aborts a transfer whose slave never becomes ready.
// Every output is driven straight from a register.
module apb3_master_bridge
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;
    // The counter holds the number of ACCESS cycles already spent without
    // pready, so it only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t state_q, state_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic [IDX_W-1:0]      dec_idx;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      tcnt_q, tcnt_d;

    logic                  cmd_ready_d;
    logic [NUM_SLAVES-1:0] psel_d;
    logic                  penable_d;
    logic                  pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d;
    logic                  rsp_timeout_d;

    logic [DATA_WIDTH-1:0] slave_rdata [NUM_SLAVES];
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    apb3_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .addr (cmd_addr),
        .sel  (dec_sel),
        .idx  (dec_idx)
    );

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_unpack
        assign slave_rdata[k] = prdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Only the slave latched at accept time is looked at; the others are ignored.
    assign sel_ready = pready[idx_q];
    assign sel_err   = pslverr[idx_q];
    assign sel_rdata = slave_rdata[idx_q];

    // Next-state and next-output logic; every register holds unless a state acts.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tcnt_d        = tcnt_q;
        cmd_ready_d   = cmd_ready;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = dec_sel;
                    idx_d       = dec_idx;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    tcnt_d      = '0;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                // Ready is checked before the timeout so a slave answering on
                // the last permitted cycle still completes normally.
                if (sel_ready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (!pwrite && !sel_err) ? sel_rdata : '0;
                end else if ((TIMEOUT > 0) && (tcnt_q == TCNT_LAST)) begin
                    state_d       = IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = '0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // State register and registered outputs with synchronous reset.
    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            // NOTE: datapath registers are reset as well; paddr, pwdata and
            // rsp_rdata are visible outputs that must come up at zero.
            state_q     <= IDLE;
            idx_q       <= '0;
            tcnt_q      <= '0;
            cmd_ready   <= 1'b1;
            psel        <= '0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tcnt_q      <= tcnt_d;
            cmd_ready   <= cmd_ready_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench for apb3_master_bridge with default parameters.
// A table of commands drives a two-slave model; expected responses go into
// a scoreboard queue at accept time and are popped when rsp_valid appears.
module tb_apb3_master_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NS = 2;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_wdata;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [NS-1:0]     psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [NS*DW-1:0]  prdata;
    logic [NS-1:0]     pready;
    logic [NS-1:0]     pslverr;

    always #5 pclk = ~pclk;

    apb3_master_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SLAVES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    // The selected slave raises pready after 'waits' ACCESS cycles (never if
    // stuck). Unselected slaves hold pready=1 and pslverr=1 as bait.
    logic [DW-1:0] rd0 = '0;
    logic [DW-1:0] rd1 = '0;
    int            waits = 0;
    logic          serr  = 1'b0;
    logic          stuck = 1'b0;
    int            acc_cnt = 0;

    always @(posedge pclk) begin
        if (psel != '0 && penable) acc_cnt <= acc_cnt + 1;
        else                       acc_cnt <= 0;
    end

    always_comb begin
        pready  = '1;
        pslverr = '1;
        for (int k = 0; k < NS; k++) begin
            if (psel[k]) begin
                pready[k]  = penable && !stuck && (acc_cnt >= waits);
                pslverr[k] = serr;
            end
        end
    end

    assign prdata = {rd1, rd0};

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          exp_cyc;
    } exp_t;

    exp_t sb_q[$];

    always @(negedge pclk) begin : monitor
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata",   rsp_rdata,          e.rdata);
                check("rsp_err",     32'(rsp_err),       32'(e.err));
                check("rsp_timeout", 32'(rsp_timeout),   32'(e.to));
                check("rsp_cycle",   32'(cyc),           32'(e.exp_cyc));
                check("rsp_ready",   32'(cmd_ready),     32'd1);
                check("rsp_psel",    32'(psel),          32'd0);
                check("rsp_penable", 32'(penable),       32'd0);
            end
        end
    end

    // ---------------- command table ----------------
    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          waits;
        logic        err;
        logic        stuck;
        logic [1:0]  exp_psel;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          lat;      // accept edge to rsp_valid, in cycles
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic do_cmd(input vec_t v);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);

        rd0   = v.rd0;
        rd1   = v.rd1;
        waits = v.waits;
        serr  = v.err;
        stuck = v.stuck;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(posedge pclk); #1;
        // cyc now names the cycle right after the accept edge (SETUP), so
        // the response lands lat-1 counts later.
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, to: v.exp_to,
                         exp_cyc: cyc + v.lat - 1});

        // Keep cmd_valid high with different values: must be ignored while busy.
        cmd_write = ~v.write;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;

        check("setup_psel",    32'(psel),      32'(v.exp_psel));
        check("setup_penable", 32'(penable),   32'd0);
        check("setup_ready",   32'(cmd_ready), 32'd0);
        check("setup_paddr",   32'(paddr),     32'(v.addr));
        check("setup_pwrite",  32'(pwrite),    32'(v.write));
        check("setup_pwdata",  pwdata,         v.wdata);

        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        check("access_psel",    32'(psel),    32'(v.exp_psel));
        check("access_penable", 32'(penable), 32'd1);
        check("access_paddr",   32'(paddr),   32'(v.addr));
        check("access_pwdata",  pwdata,       v.wdata);

        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        check("rsp_wait_expired", 32'(sb_q.size()), 32'd0);

        check("idle_psel",   32'(psel),  32'd0);
        check("idle_paddr",  32'(paddr), 32'(v.addr));
        check("idle_pwdata", pwdata,     v.wdata);
    endtask

    initial begin
        // write, addr, wdata, rd0, rd1, waits, err, stuck, psel, rdata, err, to, lat
        vecs[0] = '{1'b1, 8'h03, 32'h0000_0003, 32'h1111_1111, 32'h2222_2222, 0,  1'b0, 1'b0, 2'b01, 32'h0,         1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 8'h81, 32'h0,         32'h5A5A_5A5A, 32'hA5A5_A5A5, 2,  1'b0, 1'b0, 2'b10, 32'hA5A5_A5A5, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b0, 8'h02, 32'h0,         32'h1234_5678, 32'h0,         0,  1'b1, 1'b0, 2'b01, 32'h0,         1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 8'hC4, 32'h0,         32'h0000_0001, 32'h0000_0002, 0,  1'b0, 1'b1, 2'b10, 32'h0,         1'b1, 1'b1, 18};
        vecs[4] = '{1'b0, 8'h90, 32'h0,         32'h0,         32'h1234_5678, 15, 1'b0, 1'b0, 2'b10, 32'h1234_5678, 1'b0, 1'b0, 18};
        vecs[5] = '{1'b1, 8'h7F, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0003, 1,  1'b0, 1'b0, 2'b01, 32'h0,         1'b0, 1'b0, 4};
        vecs[6] = '{1'b0, 8'h40, 32'h0,         32'hCAFE_F00D, 32'h0BAD_0BAD, 0,  1'b0, 1'b0, 2'b01, 32'hCAFE_F00D, 1'b0, 1'b0, 3};
        vecs[7] = '{1'b1, 8'hFF, 32'h0000_00AA, 32'h0,         32'h9999_9999, 0,  1'b1, 1'b0, 2'b10, 32'h0,         1'b1, 1'b0, 3};
        vecs[8] = '{1'b0, 8'hA0, 32'h0,         32'h0000_0007, 32'h7654_3210, 14, 1'b0, 1'b0, 2'b10, 32'h7654_3210, 1'b0, 1'b0, 17};

        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = 8'hFF;
        cmd_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge pclk);
        #1;

        // Reset state.
        check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        check("rst_psel",        32'(psel),        32'd0);
        check("rst_penable",     32'(penable),     32'd0);
        check("rst_pwrite",      32'(pwrite),      32'd0);
        check("rst_paddr",       32'(paddr),       32'd0);
        check("rst_pwdata",      pwdata,           32'd0);
        check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst_rsp_rdata",   rsp_rdata,        32'd0);
        check("rst_rsp_err",     32'(rsp_err),     32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);

        presetn = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < NV; i++) begin
            do_cmd(vecs[i]);
        end

        // Reset in the middle of ACCESS: transfer dropped, no response.
        rd1   = 32'h5555_AAAA;
        waits = 0;
        serr  = 1'b0;
        stuck = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h85;
        cmd_wdata = 32'h0F0F_0F0F;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        check("mid_rst_in_access", 32'(penable), 32'd1);
        presetn = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        check("mid_rst_psel",      32'(psel),      32'd0);
        check("mid_rst_penable",   32'(penable),   32'd0);
        check("mid_rst_ready",     32'(cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_paddr",     32'(paddr),     32'd0);
        check("mid_rst_pwdata",    pwdata,         32'd0);
        // Any stray pulse over the next cycles hits the empty scoreboard.
        repeat (20) @(posedge pclk);
        #1;
        check("post_rst_idle", 32'(psel), 32'd0);

        do_cmd(vecs[0]);

        repeat (3) @(posedge pclk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb3_master_bridge.md
APB3_MASTER_BRIDGE -- requirements
Module: apb3_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, APB address width (NUM_SLAVES_LOG2+1..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width (1..32).
REQ-003 SHALL have parameter NUM_SLAVES, default 2, slave count (power of two, 1..16).
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort (0 = timeout disabled).
REQ-005 SHALL have the ports below; one clock; reset is synchronous and active-low:
  pclk  in  1  clock, all logic on rising edge
  presetn  in  1  synchronous active-low reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  bridge can accept a command
  cmd_write  in  1  1 = write, 0 = read
  cmd_addr  in  ADDR_WIDTH  target address
  cmd_wdata  in  DATA_WIDTH  write data
  rsp_valid  out  1  one-cycle response pulse
  rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
  rsp_err  out  1  slave error or timeout
  rsp_timeout  out  1  abort caused by timeout
  psel  out  NUM_SLAVES  one-hot slave select
  penable  out  1  APB access phase
  pwrite  out  1  APB direction
  paddr  out  ADDR_WIDTH  APB address
  pwdata  out  DATA_WIDTH  APB write data
  prdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data (slave k at bits [k*DATA_WIDTH +: DATA_WIDTH])
  pready  in  NUM_SLAVES  per-slave ready
  pslverr  in  NUM_SLAVES  per-slave error

Function
REQ-006 SHALL decode the slave index as cmd_addr[ADDR_WIDTH-1 -: log2(NUM_SLAVES)]; NUM_SLAVES=1 always selects slave 0.
REQ-007 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
REQ-008 IDLE: cmd_ready=1, psel=0, penable=0; cmd_valid=1 at a rising edge latches cmd_write/addr/wdata and moves to SETUP.
REQ-009 SETUP: exactly one cycle; psel one-hot for decoded slave, penable=0, cmd_ready=0; then ACCESS.
REQ-010 ACCESS: psel held, penable=1; pready of the selected slave only is sampled; pready/pslverr of unselected slaves are ignored.
REQ-011 On selected pready=1 in ACCESS: next cycle psel=0, penable=0, state IDLE, rsp_valid=1, rsp_err=selected pslverr, rsp_timeout=0, rsp_rdata=selected prdata for a clean read, else 0.
REQ-012 Latency: command accepted at edge N -> SETUP in cycle N+1, ACCESS from N+2; zero-wait transfer gives rsp_valid in cycle N+3 with cmd_ready=1 in the same cycle; minimum 3 cycles per transfer.
REQ-013 Timeout (TIMEOUT>0): counter of ACCESS cycles; if the TIMEOUT-th ACCESS cycle has pready=0, abort: psel/penable drop next cycle, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-014 pready=1 on the TIMEOUT-th ACCESS cycle SHALL complete normally (ready wins over timeout).
REQ-015 pwrite/paddr/pwdata SHALL be stable from SETUP through end of ACCESS and hold their value in IDLE until the next accepted command.
REQ-016 rsp_valid has no backpressure; it is high for exactly one cycle per accepted command.
REQ-017 cmd_valid while cmd_ready=0 SHALL be ignored, not queued.

Reset
REQ-018 presetn=0 at a rising edge SHALL force IDLE, cmd_ready=1, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter=0.
REQ-019 Reset during SETUP/ACCESS SHALL abandon the transfer with no response pulse.

Structure
REQ-020 Shared package apb3_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS) and a clog2 function.
REQ-021 Address decode SHALL be sub-module apb3_addr_decoder (cmd_addr -> one-hot select, index).

Verification
REQ-022 Defaults, write addr 0x03 data 0x3, slave0 pready=1 -> psel=2'b01 one cycle, then penable; rsp_valid 3 cycles after accept, rsp_err=0.
REQ-023 Read addr 0x81, slave1 prdata=0xA5A5A5A5, 2 wait states -> psel=2'b10, rsp_rdata=0xA5A5A5A5 on rsp_valid 5 cycles after accept.
REQ-024 Read addr 0x02, slave0 pready=1 with pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-025 Slave1 pready stuck 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; pready=1 exactly on cycle 16 -> normal completion.
REQ-026 presetn=0 during ACCESS -> next edge psel=0, penable=0, cmd_ready=1, no rsp_valid; following write completes normally.
